// File: rtl/tap_mac_filter.sv
// Time-multiplexed FIR/matched filter: snapshots the tap-delay line on each sample
// strobe and multiply-accumulates one tap per cycle against a programmable coefficient bank.
module tap_mac_filter #(
    parameter int unsigned NUM_TAPS   = 4,
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned COEF_WIDTH = 18,
    parameter int unsigned OUT_WIDTH  = 18,
    parameter int unsigned OUT_SHIFT  = 17
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] taps [0:NUM_TAPS-1],
    input  logic                         sample_valid,
    input  logic                         coef_wr_en,
    input  logic [((NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1)-1:0] coef_addr,
    input  logic signed [COEF_WIDTH-1:0] coef_wr_data,
    output logic signed [OUT_WIDTH-1:0]  filt_out,
    output logic                         filt_valid,
    output logic                         busy,
    output logic                         sat,
    output logic                         overrun,
    output logic                         coef_err
);

    localparam int unsigned IDX_W  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int unsigned PROD_W = DATA_WIDTH + COEF_WIDTH;
    localparam int unsigned ACC_W  = PROD_W + IDX_W;

    localparam logic [IDX_W-1:0]        LAST_IDX   = IDX_W'(NUM_TAPS - 1);
    localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(64'sd1 <<< (OUT_SHIFT - 1));
    localparam logic signed [ACC_W-1:0] SAT_MAX    = ACC_W'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN    = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_ROUND
    } state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic signed [DATA_WIDTH-1:0] r_snap [0:NUM_TAPS-1];
    logic signed [COEF_WIDTH-1:0] r_coef [0:NUM_TAPS-1];
    logic signed [ACC_W-1:0]      r_acc;
    logic [IDX_W-1:0]             r_idx;
    logic signed [OUT_WIDTH-1:0]  r_filt_out;
    logic                         r_filt_valid;
    logic                         r_busy;
    logic                         r_sat;
    logic                         r_overrun;
    logic                         r_coef_err;

    logic                         w_addr_ok;
    logic                         w_coef_ok;
    logic signed [PROD_W-1:0]     w_prod;
    logic signed [ACC_W-1:0]      w_sum;
    logic signed [ACC_W-1:0]      w_shift;
    logic signed [OUT_WIDTH-1:0]  w_result;
    logic                         w_clip;

    // Coefficients may only change between samples so each result uses one consistent bank.
    assign w_addr_ok = (32'(coef_addr) < NUM_TAPS);
    assign w_coef_ok = coef_wr_en && (r_state == S_IDLE) && !sample_valid && w_addr_ok;

    assign w_prod  = r_snap[r_idx] * r_coef[r_idx];
    assign w_sum   = r_acc + ROUND_HALF;
    assign w_shift = w_sum >>> OUT_SHIFT;

    // Round-half-up result clipped to the output range.
    always_comb begin
        w_clip   = 1'b0;
        w_result = w_shift[OUT_WIDTH-1:0];
        if (w_shift > SAT_MAX) begin
            w_clip   = 1'b1;
            w_result = SAT_MAX[OUT_WIDTH-1:0];
        end else if (w_shift < SAT_MIN) begin
            w_clip   = 1'b1;
            w_result = SAT_MIN[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (sample_valid) w_next = S_ACCUM;
            S_ACCUM: if (r_idx == LAST_IDX) w_next = S_ROUND;
            S_ROUND: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_TAPS); i++) begin
                r_snap[i] <= '0;
                r_coef[i] <= '0;
            end
            r_acc        <= '0;
            r_idx        <= '0;
            r_filt_out   <= '0;
            r_filt_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_sat        <= 1'b0;
            r_overrun    <= 1'b0;
            r_coef_err   <= 1'b0;
        end else begin
            r_filt_valid <= 1'b0;
            r_sat        <= 1'b0;
            r_busy       <= (w_next != S_IDLE);
            r_coef_err   <= coef_wr_en && !w_coef_ok;
            if (w_coef_ok) begin
                r_coef[coef_addr] <= coef_wr_data;
            end
            if (sample_valid && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (sample_valid) begin
                        for (int i = 0; i < int'(NUM_TAPS); i++) begin
                            r_snap[i] <= taps[i];
                        end
                        r_acc <= '0;
                        r_idx <= '0;
                    end
                end
                S_ACCUM: begin
                    r_acc <= r_acc + ACC_W'(w_prod);
                    r_idx <= r_idx + IDX_W'(1);
                end
                S_ROUND: begin
                    r_filt_out   <= w_result;
                    r_filt_valid <= 1'b1;
                    r_sat        <= w_clip;
                end
                default: ;
            endcase
        end
    end

    assign filt_out   = r_filt_out;
    assign filt_valid = r_filt_valid;
    assign busy       = r_busy;
    assign sat        = r_sat;
    assign overrun    = r_overrun;
    assign coef_err   = r_coef_err;

endmodule

// File: tb/tb_tap_mac_filter.sv
// Bench for tap_mac_filter: directed and randomized samples checked against an
// arithmetic dot-product reference with round-half-up and saturation.
module tb_tap_mac_filter;

    localparam int NT = 4;
    localparam int DW = 18;
    localparam int CW = 18;
    localparam int OW = 18;
    localparam int SH = 17;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [DW-1:0] taps [0:NT-1];
    logic                 sample_valid;
    logic                 coef_wr_en;
    logic [1:0]           coef_addr;
    logic signed [CW-1:0] coef_wr_data;
    logic signed [OW-1:0] filt_out;
    logic                 filt_valid;
    logic                 busy;
    logic                 sat;
    logic                 overrun;
    logic                 coef_err;

    int     n_vec;
    int     n_err;
    longint m_coef [0:NT-1];

    tap_mac_filter #(
        .NUM_TAPS(NT), .DATA_WIDTH(DW), .COEF_WIDTH(CW), .OUT_WIDTH(OW), .OUT_SHIFT(SH)
    ) dut (
        .clk(clk), .rst(rst), .taps(taps), .sample_valid(sample_valid),
        .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_wr_data(coef_wr_data),
        .filt_out(filt_out), .filt_valid(filt_valid), .busy(busy), .sat(sat),
        .overrun(overrun), .coef_err(coef_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [DW-1:0] rnd();
        return DW'($urandom);
    endfunction

    // Reference: exact dot product, then floor((acc + half) / 2^SH), then clip.
    function automatic longint model(output bit s);
        longint acc;
        longint r;
        longint hi;
        acc = 0;
        for (int i = 0; i < NT; i++) acc += longint'(taps[i]) * m_coef[i];
        r  = (acc + (64'sd1 <<< (SH - 1))) >>> SH;
        hi = (64'sd1 <<< (OW - 1)) - 1;
        s  = 1'b0;
        if (r > hi) begin
            r = hi;
            s = 1'b1;
        end else if (r < -hi - 1) begin
            r = -hi - 1;
            s = 1'b1;
        end
        return r;
    endfunction

    task automatic wr_coef(input int a, input longint d);
        coef_wr_en   = 1'b1;
        coef_addr    = 2'(a);
        coef_wr_data = CW'(d);
        tick();
        coef_wr_en = 1'b0;
        chk("wr_coef_err", coef_err, 0);
        m_coef[a] = d;
    endtask

    task automatic start();
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic wait_result(input int lat0, input int b0, output int lat, output int b);
        lat = lat0;
        b   = b0;
        while (!filt_valid && lat < 20) begin
            b += int'(busy);
            tick();
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input longint exp, input bit es, input int lat, input int b);
        chk({tag, "_latency"}, lat, 6);
        chk({tag, "_busy_cycles"}, b, 5);
        chk({tag, "_out"}, filt_out, exp);
        chk({tag, "_sat"}, sat, es);
    endtask

    task automatic finish_pulse(input string tag);
        tick();
        chk({tag, "_single_pulse"}, {filt_valid, sat, busy}, 0);
    endtask

    task automatic run(input string tag);
        longint exp;
        bit     es;
        int     lat;
        int     b;
        exp = model(es);
        start();
        wait_result(1, 0, lat, b);
        check_result(tag, exp, es, lat, b);
        finish_pulse(tag);
    endtask

    initial begin
        longint exp;
        bit     es;
        int     lat;
        int     b;

        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        sample_valid = 1'b0;
        coef_wr_en = 1'b0;
        coef_addr = '0;
        coef_wr_data = '0;
        for (int i = 0; i < NT; i++) begin
            taps[i]   = '0;
            m_coef[i] = 0;
        end

        // Reset held with sample_valid toggling.
        #3 rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            sample_valid = c[0];
            for (int i = 0; i < NT; i++) taps[i] = rnd();
            tick();
            chk("reset_outputs", {filt_out, filt_valid, busy, sat, overrun, coef_err}, 0);
        end
        sample_valid = 1'b0;
        rst = 1'b1;
        tick();
        run("zero_coefs");

        // Nominal: 0.5 coefficients against a ramp.
        for (int i = 0; i < NT; i++) wr_coef(i, 65536);
        for (int i = 0; i < NT; i++) taps[i] = DW'((i + 1) * 1024);
        run("nominal");
        chk("nominal_hold", filt_out, 5120);

        // Saturation in both directions.
        for (int i = 0; i < NT; i++) wr_coef(i, 131071);
        for (int i = 0; i < NT; i++) taps[i] = DW'(131071);
        run("sat_pos");
        for (int i = 0; i < NT; i++) taps[i] = DW'(-131072);
        run("sat_neg");
        chk("sat_neg_hold", filt_out, -131072);

        // Overrun with shifting taps, then back-to-back accept on the result cycle.
        for (int i = 0; i < NT; i++) wr_coef(i, 65536);
        for (int i = 0; i < NT; i++) taps[i] = DW'((i + 1) * 1024);
        exp = model(es);
        start();
        tick();
        for (int i = 0; i < NT; i++) taps[i] = rnd();
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        chk("overrun_set", overrun, 1);
        wait_result(3, 2, lat, b);
        check_result("snapshot", exp, es, lat, b);
        chk("snapshot_const", filt_out, 5120);
        for (int i = 0; i < NT; i++) taps[i] = rnd();
        exp = model(es);
        start();
        chk("b2b_accept", {filt_valid, busy}, 1);
        wait_result(1, 0, lat, b);
        check_result("b2b", exp, es, lat, b);
        finish_pulse("b2b");
        chk("overrun_sticky", overrun, 1);

        // Coefficient write while busy is rejected.
        for (int i = 0; i < NT; i++) taps[i] = rnd();
        exp = model(es);
        start();
        tick();
        coef_wr_en = 1'b1;
        coef_addr = 2'd2;
        coef_wr_data = CW'(-5000);
        tick();
        coef_wr_en = 1'b0;
        chk("coef_err_busy", coef_err, 1);
        wait_result(3, 2, lat, b);
        check_result("coef_busy", exp, es, lat, b);
        chk("coef_err_pulse", coef_err, 0);
        finish_pulse("coef_busy");
        run("coef_old");

        // Write coincident with an accepted sample is rejected.
        for (int i = 0; i < NT; i++) taps[i] = rnd();
        exp = model(es);
        coef_wr_en = 1'b1;
        coef_addr = 2'd0;
        coef_wr_data = CW'(12345);
        start();
        coef_wr_en = 1'b0;
        chk("coef_err_coinc", coef_err, 1);
        wait_result(1, 0, lat, b);
        check_result("coef_coinc", exp, es, lat, b);
        finish_pulse("coef_coinc");

        // Idle write takes effect on the next sample.
        wr_coef(2, longint'(rnd()));
        run("coef_new");

        // Randomized coefficients and taps.
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < NT; i++) wr_coef(i, longint'(rnd()));
            for (int i = 0; i < NT; i++) taps[i] = rnd();
            run("random");
        end

        // Reset mid-accumulation abandons the sample and clears the bank.
        for (int i = 0; i < NT; i++) taps[i] = rnd();
        start();
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_busy", {busy, filt_valid, overrun}, 0);
        for (int c = 0; c < 7; c++) begin
            tick();
            chk("midrst_no_valid", filt_valid, 0);
        end
        rst = 1'b1;
        for (int i = 0; i < NT; i++) begin
            m_coef[i] = 0;
            taps[i]   = DW'(131071);
        end
        tick();
        run("post_reset");
        chk("post_reset_zero", filt_out, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tap_mac_filter.md
Name: tap_mac_filter

Overview:
- Time-multiplexed FIR/matched filter directly downstream of the tap-delay `fifo` in the BPSK receive path.
- On each sample strobe it snapshots all FIFO taps and multiply-accumulates them against a programmable coefficient bank, one tap per cycle.
- Emits one rounded, saturated filter output per accepted sample, with a valid pulse to the next stage (demod/slicer).

Parameters:
NUM_TAPS, 4, tap count; equals the upstream FIFO_SIZE.
DATA_WIDTH, 18, signed tap width; equals the upstream DATA_WIDTH.
COEF_WIDTH, 18, signed coefficient width, Q1.(COEF_WIDTH-1).
OUT_WIDTH, 18, signed output width.
OUT_SHIFT, 17, arithmetic right shift applied to the accumulator before saturation.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
taps  in  NUM_TAPS x DATA_WIDTH  unpacked array [0:NUM_TAPS-1], wired to the upstream fifo_out
sample_valid  in  1  one-cycle strobe: taps hold a new sample set this cycle
coef_wr_en  in  1  coefficient write strobe
coef_addr  in  clog2(NUM_TAPS)  coefficient index
coef_wr_data  in  COEF_WIDTH  signed coefficient value
filt_out  out  OUT_WIDTH  signed filter result
filt_valid  out  1  one-cycle pulse: filt_out is new
busy  out  1  high while a sample is being processed
sat  out  1  high with filt_valid when the current result was clipped
overrun  out  1  sticky: a sample_valid was dropped while busy
coef_err  out  1  one-cycle pulse: a coefficient write was rejected

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Coefficient bank clears to 0 and the accumulator clears.
- Arithmetic:
  - Signed two's complement throughout.
  - Accumulator width is DATA_WIDTH+COEF_WIDTH+clog2(NUM_TAPS) (38 at defaults), so there is no internal overflow.
  - Result = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, i.e. round half up.
  - The result is then saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; sat=1 when clipping occurs.
- FSM states: IDLE, ACCUM, ROUND.
  - IDLE: on sample_valid, latch taps[0..NUM_TAPS-1] into a local snapshot, clear acc, tap index=0, go to ACCUM, busy=1 from the next cycle.
  - ACCUM: acc += snap[idx]*coef[idx], idx++. After NUM_TAPS cycles (idx=NUM_TAPS-1 consumed) go to ROUND.
  - ROUND: compute rounded/saturated result, register it to filt_out, pulse filt_valid and sat for one cycle, busy=0, return to IDLE.
- Latency:
  - sample_valid sampled at edge E0; filt_valid is high during the cycle after edge E0+NUM_TAPS+1 (6 edges at defaults).
  - Accepted sample rate is at most one per NUM_TAPS+2 cycles.
  - sample_valid may be accepted in the same cycle filt_valid is high, since the FSM is back in IDLE.
- filt_out holds its value between pulses and changes only on a new result.
- Snapshot isolation: upstream taps may shift freely during ACCUM; the result uses only the snapshot.
- sample_valid while busy:
  - The sample is dropped and overrun is set.
  - overrun clears only on reset. The in-flight computation is unaffected.
- Coefficient writes:
  - In IDLE without a simultaneous sample_valid, coef[coef_addr] <= coef_wr_data.
  - When busy, or coincident with an accepted sample_valid, the write is ignored and coef_err pulses for one cycle. This keeps coefficients stable per sample.
  - coef_addr >= NUM_TAPS (non-power-of-two NUM_TAPS only) is ignored and coef_err pulses.
- Reset mid-operation: computation is abandoned, no filt_valid is produced, and the bank clears.

Test Plan:
1. Reset: hold rst=0 with sample_valid toggling -> all outputs 0, no filt_valid. Release rst, pulse sample_valid with taps nonzero -> filt_out=0 (coefs zero), filt_valid after 6 edges.
2. Nominal:
   - Write coef[0..3]=65536 (0.5).
   - Taps={1024,2048,3072,4096} (ramp <<10), pulse sample_valid.
   - Expect filt_out=5120, sat=0, busy high for exactly 5 cycles, filt_valid a single 1-cycle pulse.
3. Saturation:
   - Positive: taps all 131071, coefs all 131071 -> filt_out=131071, sat=1.
   - Negative: taps all -131072, coefs 131071 -> filt_out=-131072, sat=1.
4. Overrun / snapshot:
   - Pulse sample_valid, change taps and pulse sample_valid again 2 cycles later.
   - Expect the first result to be unchanged (5120 case), overrun=1 sticky, only one filt_valid.
   - Expect a back-to-back accept on the filt_valid cycle to succeed.
5. Coefficient guard:
   - coef_wr_en during ACCUM -> coef_err pulse, result unchanged; next sample uses the old coefs.
   - Write in IDLE -> no coef_err; the next sample reflects the new coef.
6. Reset mid-ACCUM: assert rst 2 cycles after sample_valid -> no filt_valid, busy=0 immediately, coefs read back 0 (next sample gives filt_out=0).
